// File: rtl/uniform_coeff_packer.sv
// Compacts sparse sampler lanes into a dense buffer and emits fixed-width coefficient beats.
// Counts exactly N_COEFFS accepted coefficients per polynomial and pulses done once fully drained.
module uniform_coeff_packer #(
  parameter int LANES     = 8,
  parameter int CAND_BITS = 16,
  parameter int COEF_BITS = 12,
  parameter int OUT_LANES = 4,
  parameter int BUF_DEPTH = 16,
  parameter int N_COEFFS  = 256
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [LANES*CAND_BITS-1:0]     sampled_vals,
  input  logic [LANES-1:0]               sampled_valid,
  output logic                           in_ready,
  output logic [OUT_LANES*COEF_BITS-1:0] out_coeffs,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(N_COEFFS+1)-1:0]  coeff_count
);

  localparam int CW = $clog2(N_COEFFS+1);
  localparam int BW = $clog2(BUF_DEPTH+1);
  localparam int RW = $clog2(LANES+1);
  localparam int PW = $clog2(BUF_DEPTH+LANES+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]           state_reg;
  logic [COEF_BITS-1:0] buf_reg  [BUF_DEPTH];
  logic [COEF_BITS-1:0] buf_next [BUF_DEPTH];
  logic [BW-1:0]        buf_count_reg, buf_count_next;
  logic [CW-1:0]        accepted_reg, accepted_next;
  logic [CW-1:0]        emitted_reg, emitted_next;

  logic                 pop;
  logic                 accept;
  logic [BW-1:0]        base;
  logic [CW-1:0]        remaining;
  logic [CW-1:0]        appended;
  logic [RW-1:0]        total;
  logic [COEF_BITS-1:0] lane_val [LANES];
  logic [RW-1:0]        rank     [LANES];
  logic [PW-1:0]        pos      [LANES];
  logic [LANES-1:0]     take;
  logic [LANES-1:0]     unused_hi;

  assign in_ready    = (state_reg == S_FILL) && (buf_count_reg <= BW'(BUF_DEPTH - LANES))
                       && (accepted_reg < CW'(N_COEFFS));
  assign out_valid   = (buf_count_reg >= BW'(OUT_LANES));
  assign pop         = out_valid && out_ready;
  assign accept      = in_ready && (|sampled_valid);
  assign base        = pop ? (buf_count_reg - BW'(OUT_LANES)) : buf_count_reg;
  assign remaining   = CW'(N_COEFFS) - accepted_reg;
  assign total       = RW'($countones(sampled_valid));
  assign busy        = (state_reg != S_IDLE);
  assign done        = (state_reg == S_DONE);
  assign coeff_count = accepted_reg;

  // A lane's slot is the number of valid lanes below it; the quota cuts off the highest ranks.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [LANES-1:0] BELOW = LANES'((64'd1 << gi) - 64'd1);
      assign lane_val[gi]  = sampled_vals[gi*CAND_BITS +: COEF_BITS];
      assign unused_hi[gi] = ^sampled_vals[gi*CAND_BITS+COEF_BITS +: CAND_BITS-COEF_BITS];
      assign rank[gi]      = RW'($countones(sampled_valid & BELOW));
      assign take[gi]      = accept && sampled_valid[gi] && (CW'(rank[gi]) < remaining);
      assign pos[gi]       = PW'(base) + PW'(rank[gi]);
    end
    for (gi = 0; gi < OUT_LANES; gi++) begin : g_out
      assign out_coeffs[gi*COEF_BITS +: COEF_BITS] = buf_reg[gi];
    end
  endgenerate

  always_comb begin
    appended = '0;
    if (accept) begin
      appended = (CW'(total) < remaining) ? CW'(total) : remaining;
    end
  end

  assign buf_count_next = buf_count_reg - (pop ? BW'(OUT_LANES) : BW'(0)) + BW'(appended);
  assign accepted_next  = accepted_reg + appended;
  assign emitted_next   = pop ? (emitted_reg + CW'(OUT_LANES)) : emitted_reg;

  // Pop shifts the survivors down first; new lanes then land directly behind them.
  always_comb begin
    buf_next = buf_reg;
    if (pop) begin
      for (int e = 0; e < BUF_DEPTH - OUT_LANES; e++) begin
        buf_next[e] = buf_reg[e + OUT_LANES];
      end
      for (int e = BUF_DEPTH - OUT_LANES; e < BUF_DEPTH; e++) begin
        buf_next[e] = '0;
      end
    end
    for (int e = 0; e < BUF_DEPTH; e++) begin
      for (int j = 0; j < LANES; j++) begin
        if (take[j] && (pos[j] == PW'(e))) begin
          buf_next[e] = lane_val[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      buf_count_reg <= '0;
      accepted_reg  <= '0;
      emitted_reg   <= '0;
      for (int e = 0; e < BUF_DEPTH; e++) begin
        buf_reg[e] <= '0;
      end
    end else begin
      buf_reg       <= buf_next;
      buf_count_reg <= buf_count_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg     <= S_FILL;
            accepted_reg  <= '0;
            emitted_reg   <= '0;
            buf_count_reg <= '0;
          end
        end
        S_FILL: begin
          accepted_reg <= accepted_next;
          emitted_reg  <= emitted_next;
          if (accepted_next == CW'(N_COEFFS)) begin
            state_reg <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          emitted_reg <= emitted_next;
          if (emitted_next == CW'(N_COEFFS)) begin
            state_reg <= S_DONE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uniform_coeff_packer.sv
// Directed bench for uniform_coeff_packer: a coefficient queue is filled as beats are driven
// and drained four at a time whenever the packer hands over an output beat.
module tb_uniform_coeff_packer;

  localparam int LANES = 8;
  localparam int CB    = 16;
  localparam int KB    = 12;
  localparam int OL    = 4;
  localparam int N     = 256;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [LANES*CB-1:0]  sampled_vals;
  logic [LANES-1:0]     sampled_valid;
  logic                 in_ready;
  logic [OL*KB-1:0]     out_coeffs;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;
  logic [8:0]           coeff_count;

  int vectors = 0;
  int miscompares = 0;
  int acc_m = 0;
  int cyc = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_pop_cyc = -1;
  logic [OL*KB-1:0] last_beat;
  logic [KB-1:0] exp_q[$];

  uniform_coeff_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sampled_vals(sampled_vals), .sampled_valid(sampled_valid),
    .in_ready(in_ready), .out_coeffs(out_coeffs), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .coeff_count(coeff_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output scoreboard: a handshake seen at the falling edge is consumed on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [OL*KB-1:0] exp_beat;
      exp_beat = '0;
      vectors++;
      if (exp_q.size() < OL) begin
        miscompares++;
        $error("FAIL beat_extra observed=%0h expected=no_beat (queue=%0d)", out_coeffs, exp_q.size());
      end else begin
        for (int j = 0; j < OL; j++) exp_beat[j*KB +: KB] = exp_q.pop_front();
        assert (out_coeffs === exp_beat) else begin
          miscompares++;
          $error("FAIL beat observed=%0h expected=%0h", out_coeffs, exp_beat);
        end
      end
      beats_seen++;
      last_pop_cyc = cyc;
      last_beat = out_coeffs;
    end
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one input beat once the packer is ready; lane i carries base+i.
  task automatic send(input logic [7:0] mask, input logic [15:0] base);
    int waited;
    logic [15:0] v;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 60) begin
      tick();
      waited++;
    end
    check("send_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < LANES; i++) sampled_vals[i*CB +: CB] = base + 16'(i);
    sampled_valid = mask;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i] && acc_m < N) begin
        v = base + 16'(i);
        exp_q.push_back(v[KB-1:0]);
        acc_m++;
      end
    end
    tick();
    sampled_valid = '0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats0;
    int k;
    rst_n = 1'b0;
    start = 1'b1;
    out_ready = 1'b0;
    sampled_valid = '0;
    sampled_vals = '0;

    // Reset with random activity on every input.
    for (int r = 0; r < 4; r++) begin
      sampled_vals  = {$urandom, $urandom, $urandom, $urandom};
      sampled_valid = 8'($urandom);
      out_ready     = 1'($urandom);
      tick();
      check("rst_busy", 64'(busy), 64'd0);
    end
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_coeffs", 64'(out_coeffs), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_coeff_count", 64'(coeff_count), 64'd0);
    rst_n = 1'b1;
    start = 1'b0;
    sampled_valid = '0;
    out_ready = 1'b1;
    tick();
    check("idle_after_rst", 64'(busy), 64'd0);

    // Dense beat.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_count", 64'(coeff_count), 64'd0);
    send(8'hFF, 16'h0000);
    check("dense_latency_valid", 64'(out_valid), 64'd1);
    check("dense_first_beat", 64'(out_coeffs), 64'h003002001000);

    // Sparse beat then an empty mask.
    send(8'hA5, 16'h0100);
    send(8'h00, 16'h0200);
    check("sparse_count", 64'(coeff_count), 64'(acc_m));

    // Backpressure from an empty buffer.
    k = 0;
    while (exp_q.size() != 0 && k < 40) begin tick(); k++; end
    tick();
    check("drained_before_bp", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    send(8'hFF, 16'h0020);
    send(8'hFF, 16'h0030);
    check("bp_full_in_ready", 64'(in_ready), 64'd0);
    check("bp_full_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < LANES; i++) sampled_vals[i*CB +: CB] = 16'h0040 + 16'(i);
    sampled_valid = 8'hFF;
    tick();
    sampled_valid = '0;
    check("bp_third_dropped", 64'(coeff_count), 64'(acc_m));
    out_ready = 1'b1;
    tick();
    check("bp_12_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("bp_8_in_ready", 64'(in_ready), 64'd1);

    // Start while busy is ignored; then abandon the polynomial at 100 coefficients.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_start_ignored", 64'(coeff_count), 64'(acc_m));
    check("busy_start_busy", 64'(busy), 64'd1);
    for (int b = 0; b < 9; b++) send(8'hFF, 16'h0100 + 16'(8*b));
    check("midop_count", 64'(coeff_count), 64'd100);
    rst_n = 1'b0;
    exp_q.delete();
    acc_m = 0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_count", 64'(coeff_count), 64'd0);
    repeat (3) tick();
    check("midrst_no_done", 64'(done_cnt), 64'd0);

    // Full polynomial with the quota cutting the last beat.
    start = 1'b1;
    tick();
    start = 1'b0;
    beats0 = beats_seen;
    for (int b = 0; b < 30; b++) send(8'hFF, 16'(8*b));
    check("quota_240", 64'(coeff_count), 64'd240);
    send(8'h0F, 16'd240);
    send(8'hFF, 16'd244);
    send(8'hFF, 16'h0800);
    check("quota_count", 64'(coeff_count), 64'd256);
    check("quota_in_ready", 64'(in_ready), 64'd0);
    check("quota_busy", 64'(busy), 64'd1);
    k = 0;
    while (done !== 1'b1 && k < 300) begin tick(); k++; end
    check("done_seen", 64'(done), 64'd1);
    // start during DONE must not launch a new polynomial.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("done_pulse_width", 64'(done), 64'd0);
    check("done_start_ignored", 64'(busy), 64'd0);
    check("done_count_held", 64'(coeff_count), 64'd256);
    check("quota_beats", 64'(beats_seen - beats0), 64'd64);
    check("quota_last_beat", 64'(last_beat), 64'h803802801800);
    check("done_after_last_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (4) tick();
    check("done_once", 64'(done_cnt), 64'd1);
    check("idle_stays", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uniform_coeff_packer.md
Name: uniform_coeff_packer

Overview:
- Sits directly downstream of uniform_sampler.
- Takes its sparse per-lane accepted candidates (sampled_vals / sampled_valid) and compacts them, in lane order, into a dense FIFO-like buffer.
- Emits fixed-width beats of OUT_LANES coefficients under a valid/ready handshake.
- Counts exactly N_COEFFS accepted coefficients per polynomial, discards any surplus, and pulses done when the polynomial has fully drained.

Parameters:
- LANES, 8, input lanes per beat (matches sampler).
- CAND_BITS, 16, width of each input candidate.
- COEF_BITS, 12, width of each output coefficient (low bits of candidate).
- OUT_LANES, 4, coefficients per output beat; must divide N_COEFFS.
- BUF_DEPTH, 16, compaction buffer entries; must be >= LANES + OUT_LANES.
- N_COEFFS, 256, coefficients per polynomial.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begin a new polynomial; honoured only in IDLE.
- sampled_vals  in  LANES*CAND_BITS  candidates; lane i at bits [i*CAND_BITS +: CAND_BITS].
- sampled_valid  in  LANES  per-lane accept mask from sampler.
- in_ready  out  1  packer can absorb a full beat this cycle.
- out_coeffs  out  OUT_LANES*COEF_BITS  packed coefficients; lane 0 is the oldest.
- out_valid  out  1  out_coeffs holds OUT_LANES valid coefficients.
- out_ready  in  1  downstream consumes the beat when out_valid is also high.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at polynomial completion.
- coeff_count  out  $clog2(N_COEFFS+1)  coefficients accepted so far this polynomial.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - Buffer count, accepted count and emitted count = 0.
  - in_ready=0, out_valid=0, out_coeffs=0, busy=0, done=0, coeff_count=0.
  - Reset mid-operation abandons the polynomial entirely; buffer contents are not emitted.
- States:
  - IDLE: in_ready=0. start=1 -> FILL; counters clear on that edge.
  - FILL: in_ready = (buf_count <= BUF_DEPTH-LANES) && (accepted < N_COEFFS).
    - Input accept occurs at a posedge with in_ready=1 and |sampled_valid=1.
    - An all-zero mask is a no-op.
    - Goes to DRAIN on the edge where accepted reaches N_COEFFS.
  - DRAIN: in_ready=0. Goes to DONE on the edge where emitted reaches N_COEFFS.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. start in the same cycle as DONE is ignored; it must be re-asserted in IDLE.
- Compaction:
  - Valid lanes are appended in ascending lane index order.
  - Each lane contributes sampled_vals lane [COEF_BITS-1:0].
  - Invalid lanes are skipped with no gaps.
- Quota:
  - If popcount(mask) > N_COEFFS-accepted, only the lowest-indexed valid lanes up to the quota are appended.
  - The rest are dropped silently.
  - accepted never exceeds N_COEFFS.
- Output:
  - out_valid = (buf_count >= OUT_LANES); it is registered state, not derived from the current input.
  - out_coeffs lane j = buffer entry j (oldest first).
  - Pop occurs when out_valid && out_ready: remove OUT_LANES entries and emitted += OUT_LANES.
  - Data held stable while out_valid=1 and out_ready=0.
- Simultaneous pop and append in one cycle: the pop is applied first, then the append goes behind the remaining entries. New buf_count = old - pop + appended.
- Latency: coefficients appended at posedge k are visible on out_coeffs after posedge k (same edge that updates buf_count); minimum input-to-output latency is 1 cycle.
- in_ready uses the pre-pop count (conservative); overflow is impossible by construction.
- coeff_count mirrors accepted. It holds its value through DONE and clears on the next start.
- Widths: candidates are truncated to COEF_BITS with no range check; the sampler already guarantees value < q.

Test Plan:
- Reset: hold rst_n=0 for 4 cycles with random inputs -> all outputs 0, in_ready=0. start during reset is ignored.
- Dense beat: start, then mask 0xFF with lane i = i, out_ready=1 -> next cycle out_coeffs={3,2,1,0} (lane0=0); the following cycle {7,6,5,4}.
- Sparse beat: mask 8'hA5 with lane i = 16'h0100+i -> one beat, lanes 0..3 = 0x100, 0x102, 0x105, 0x107. Also mask 0x00 -> no change.
- Backpressure: out_ready=0, two 0xFF beats -> buf_count=16, in_ready=0, a third beat is not taken. Then raise out_ready -> beats drain in order and in_ready returns once buf_count <= 8.
- Quota: 30 beats 0xFF (240), then 0x0F (244), then 0xFF (252), then 0xFF with lane i=0x800+i.
  - Only lanes 0..3 of the last beat are accepted; coeff_count=256; state moves to DRAIN.
  - Exactly 64 output beats are produced; the last beat is {0x803,0x802,0x801,0x800}.
  - done pulses once, one cycle after the 64th pop.
- Mid-op: start pulse while busy is ignored. Then rst_n=0 after 100 coefficients -> IDLE, buffer empty, no done. A new start runs a full 256 cleanly.
